// File: rtl/tug_playfield_if.sv
// Player-side signal bundle of the tug-of-war light-position stage.
//   master : drives raw keys and the round restart, observes light/presses/busy
//   slave  : the playfield itself
// Signals:
//   key_l, key_r : raw asynchronous player keys, active-high
//   restart      : synchronous round restart from the victory stage
//   led          : one-hot light position, led[N_LEDS-1] leftmost
//   l_press      : conditioned left press, one cycle wide
//   r_press      : conditioned right press, one cycle wide
//   busy         : high while presses are locked out
interface tug_playfield_if #(
  parameter int unsigned N_LEDS = 9
);
  logic              key_l;
  logic              key_r;
  logic              restart;
  logic [N_LEDS-1:0] led;
  logic              l_press;
  logic              r_press;
  logic              busy;

  modport master (
    output key_l, key_r, restart,
    input  led, l_press, r_press, busy
  );

  modport slave (
    input  key_l, key_r, restart,
    output led, l_press, r_press, busy
  );
endinterface

// File: rtl/tug_playfield.sv
// Light-position stage of the tug-of-war game. Synchronises and edge-detects
// the two raw player keys into single-cycle press pulses and walks a single
// lit LED one step per press across an N_LEDS-wide playfield. A round restart
// re-centres the light and starts a LOCKOUT-cycle window in which presses are
// ignored.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : tug_playfield_if slave modport (keys, restart in; led, presses,
//           busy out)
module tug_playfield #(
  parameter int unsigned N_LEDS  = 9,
  parameter int unsigned LOCKOUT = 8
) (
  input logic              clk,
  input logic              reset,
  tug_playfield_if.slave   bus
);

  localparam int unsigned CntW = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);
  localparam int unsigned PosW = (N_LEDS < 2) ? 1 : $clog2(N_LEDS);

  localparam logic [PosW-1:0]   Centre  = PosW'((N_LEDS - 1) / 2);
  localparam logic [PosW-1:0]   LastPos = PosW'(N_LEDS - 1);
  localparam logic [CntW-1:0]   CntLoad = CntW'(LOCKOUT);
  localparam logic [N_LEDS-1:0] LedOne  = N_LEDS'(1);

  typedef enum logic {StLock, StPlay} state_e;

  localparam state_e StStart = (LOCKOUT == 0) ? StPlay : StLock;

  // Bit 1 is the left key, bit 0 the right key.
  logic [1:0] key_s1_q, key_s2_q, key_h_q;
  logic [1:0] press_d, press_q;

  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            busy_d, busy_q;
  logic [PosW-1:0] pos_d, pos_q;

  // Sync and history preset to 1 so a key held through reset needs a fresh
  // release/press before it can pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q <= 2'b11;
      key_s2_q <= 2'b11;
      key_h_q  <= 2'b11;
    end else begin
      key_s1_q <= {bus.key_l, bus.key_r};
      key_s2_q <= key_s1_q;
      key_h_q  <= key_s2_q;
    end
  end

  // History keeps running in lockout, so a press made there is swallowed.
  always_comb begin
    press_d = key_s2_q & ~key_h_q & {2{state_q == StPlay}} & {2{~bus.restart}};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.restart) begin
      state_d = StStart;
      cnt_d   = CntLoad;
    end else if (state_q == StLock) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        state_d = StPlay;
      end
    end
    busy_d = (state_d == StLock);
  end

  // Movement uses the registered pulses, so the light lags the pulse by a cycle.
  always_comb begin
    pos_d = pos_q;
    if (bus.restart) begin
      pos_d = Centre;
    end else if (state_q == StPlay) begin
      case (press_q)
        2'b10: if (pos_q != LastPos) pos_d = pos_q + PosW'(1);
        2'b01: if (pos_q != '0)      pos_d = pos_q - PosW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StStart;
      cnt_q   <= CntLoad;
      busy_q  <= (LOCKOUT > 0);
      pos_q   <= Centre;
      press_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pos_q   <= pos_d;
      press_q <= press_d;
    end
  end

  assign bus.led     = LedOne << pos_q;
  assign bus.l_press = press_q[1];
  assign bus.r_press = press_q[0];
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_tug_playfield.sv
module tb_tug_playfield;

  localparam int N  = 9;
  localparam int LK = 4;
  localparam int C  = (N - 1) / 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tug_playfield_if #(.N_LEDS(N)) bus ();

  tug_playfield #(
    .N_LEDS (N),
    .LOCKOUT(LK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: keys sampled each edge; a press is a low-to-high step
  // in the samples taken two edges ago, honoured only while not locked out.
  bit       mvalid = 1'b0;
  int       mpos;
  int       mlock;   // lockout cycles still to run
  bit       mpl, mpr;
  bit [2:0] hl, hr;  // [0] newest sample

  always @(posedge clk) begin
    bit playing, pl_n, pr_n;
    if (reset) begin
      mvalid = 1'b1;
      mpos   = C;
      mlock  = LK;
      mpl    = 1'b0;
      mpr    = 1'b0;
      hl     = 3'b111;
      hr     = 3'b111;
    end else if (mvalid) begin
      playing = (mlock == 0);
      pl_n    = hl[1] && !hl[2] && playing && !bus.restart;
      pr_n    = hr[1] && !hr[2] && playing && !bus.restart;
      if (bus.restart) begin
        mpos  = C;
        mlock = LK;
      end else begin
        if (playing) begin
          if (mpl && !mpr && mpos < N - 1) mpos = mpos + 1;
          else if (mpr && !mpl && mpos > 0) mpos = mpos - 1;
        end
        if (mlock > 0) mlock = mlock - 1;
      end
      mpl = pl_n;
      mpr = pr_n;
      hl  = {hl[1:0], bus.key_l};
      hr  = {hr[1:0], bus.key_r};
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eled;
    if (mvalid) begin
      eled = 9'd1 << mpos;
      chk("model_led", bus.led, eled);
      chk("model_l_press", bus.l_press, mpl);
      chk("model_r_press", bus.r_press, mpr);
      chk("model_busy", bus.busy, mlock > 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle key pulse; returns in the cycle the press pulse is high.
  task automatic press(input bit l, input bit r);
    bus.key_l = l;
    bus.key_r = r;
    step();
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    step();
    step();
  endtask

  logic [N-1:0] lpre  [5] = '{9'h010, 9'h020, 9'h040, 9'h080, 9'h100};
  logic [N-1:0] lpost [5] = '{9'h020, 9'h040, 9'h080, 9'h100, 9'h100};
  logic         bexp  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    bus.key_l   = 1'b0;
    bus.key_r   = 1'b0;
    bus.restart = 1'b0;
    reset       = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state and lockout window
    chk("rst_led", bus.led, 9'h010);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_l_press", bus.l_press, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("idle_busy", bus.busy, bexp[i]);
      chk("idle_led", bus.led, 9'h010);
    end

    // Walk left to the edge and saturate
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0);
      chk("left_pulse", bus.l_press, 1'b1);
      chk("left_led_pre", bus.led, lpre[i]);
      step();
      chk("left_pulse_end", bus.l_press, 1'b0);
      chk("left_led_post", bus.led, lpost[i]);
    end

    // Simultaneous press: both pulses, no move
    press(1'b1, 1'b1);
    chk("both_l", bus.l_press, 1'b1);
    chk("both_r", bus.r_press, 1'b1);
    step();
    chk("both_led", bus.led, 9'h100);

    // Walk right to the right edge
    for (int i = 0; i < 8; i++) begin
      press(1'b0, 1'b1);
      step();
    end
    chk("right_edge", bus.led, 9'h001);

    // Right press lands on the restart edge
    bus.key_r = 1'b1;
    step();
    bus.key_r = 1'b0;
    step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    chk("rs_r_press", bus.r_press, 1'b0);
    chk("rs_led", bus.led, 9'h010);
    chk("rs_busy0", bus.busy, 1'b1);
    bus.key_l = 1'b1;
    step();
    bus.key_l = 1'b0;
    chk("rs_busy1", bus.busy, 1'b1);
    step();
    chk("rs_busy2", bus.busy, 1'b1);
    step();
    chk("rs_busy3", bus.busy, 1'b1);
    chk("rs_lock_press", bus.l_press, 1'b0);
    step();
    chk("rs_busy_end", bus.busy, 1'b0);
    chk("rs_lock_press2", bus.l_press, 1'b0);
    step();
    step();
    chk("rs_led_hold", bus.led, 9'h010);

    // Key held through reset
    bus.key_r = 1'b1;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_r_press", bus.r_press, 1'b0);
    end
    bus.key_r = 1'b0;
    step();
    step();
    press(1'b0, 1'b1);
    chk("held_repress", bus.r_press, 1'b1);
    step();
    chk("held_led", bus.led, 9'h008);

    // Reset mid-play
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0);
      step();
    end
    chk("mid_led_pre", bus.led, 9'h080);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_led", bus.led, 9'h010);
    chk("mid_l_press", bus.l_press, 1'b0);
    chk("mid_r_press", bus.r_press, 1'b0);
    chk("mid_busy", bus.busy, 1'b1);
    step();
    chk("mid_after_l", bus.l_press, 1'b0);
    for (int i = 0; i < 5; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
